// File: rtl/render_pkg.sv
// Shared definitions for the particle render path: position word layout,
// fp16 field positions and the streamer state encoding.
package render_pkg;

  localparam int POS_W     = 48;
  localparam int FP16_W    = 16;
  localparam int X_MSB     = 47;
  localparam int X_LSB     = 32;
  localparam int Y_MSB     = 31;
  localparam int Y_LSB     = 16;
  localparam int Z_MSB     = 15;
  localparam int Z_LSB     = 0;
  localparam int FP16_SIGN = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_RDY,
    ST_EMIT,
    ST_DONE
  } state_t;

  // Particles behind the camera (negative z) or exactly on the plane (+/-0) are culled.
  function automatic logic fp16_cull(input logic [FP16_W-1:0] z);
    return z[FP16_SIGN] || (z[FP16_SIGN-1:0] == '0);
  endfunction

endpackage

// File: rtl/particle_streamer.sv
// Walks the position memory once per frame, culls particles with z <= 0 and
// hands the survivors to the renderer one strobe at a time.
module particle_streamer
  import render_pkg::*;
#(
  parameter int NUM_PARTICLES = 64,
  parameter int ADDR_W        = 6,
  parameter int MEM_LATENCY   = 2,
  parameter int READY_HOLDOFF = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_start_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic [POS_W-1:0]  mem_data_in,
  input  logic              render_ready_in,
  output logic [FP16_W-1:0] f_x_out,
  output logic [FP16_W-1:0] f_y_out,
  output logic [FP16_W-1:0] f_z_out,
  output logic              data_valid_out,
  output logic              busy_out,
  output logic              frame_done_out,
  output logic [ADDR_W:0]   emitted_count_out
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_PARTICLES - 1);
  localparam logic [7:0]        LAT_LAST  = 8'(MEM_LATENCY - 1);
  localparam logic [7:0]        HOLD_LOAD = 8'(READY_HOLDOFF);

  state_t            state;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W:0]   count;
  logic [7:0]        lat_cnt;
  logic [7:0]        hold_cnt;
  logic [FP16_W-1:0] hold_x;
  logic [FP16_W-1:0] hold_y;
  logic [FP16_W-1:0] hold_z;
  logic              last;

  assign last = (index == LAST_IDX);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= ST_IDLE;
      index             <= '0;
      count             <= '0;
      lat_cnt           <= '0;
      hold_cnt          <= '0;
      hold_x            <= '0;
      hold_y            <= '0;
      hold_z            <= '0;
      mem_addr_out      <= '0;
      f_x_out           <= '0;
      f_y_out           <= '0;
      f_z_out           <= '0;
      data_valid_out    <= 1'b0;
      busy_out          <= 1'b0;
      frame_done_out    <= 1'b0;
      emitted_count_out <= '0;
    end else begin
      data_valid_out <= 1'b0;
      frame_done_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start_in) begin
            index        <= '0;
            count        <= '0;
            lat_cnt      <= '0;
            hold_cnt     <= '0;
            mem_addr_out <= '0;
            busy_out     <= 1'b1;
            state        <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt <= '0;
            hold_x  <= mem_data_in[X_MSB:X_LSB];
            hold_y  <= mem_data_in[Y_MSB:Y_LSB];
            hold_z  <= mem_data_in[Z_MSB:Z_LSB];
            if (!fp16_cull(mem_data_in[Z_MSB:Z_LSB])) begin
              state <= ST_WAIT_RDY;
            end else if (last) begin
              frame_done_out    <= 1'b1;
              emitted_count_out <= count;
              state             <= ST_DONE;
            end else begin
              index        <= index + 1'b1;
              mem_addr_out <= index + 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        ST_WAIT_RDY: begin
          // Ready is only honoured once the post-emit holdoff has drained.
          if (hold_cnt != 8'd0) begin
            hold_cnt <= hold_cnt - 8'd1;
          end else if (render_ready_in) begin
            f_x_out        <= hold_x;
            f_y_out        <= hold_y;
            f_z_out        <= hold_z;
            data_valid_out <= 1'b1;
            state          <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          count    <= count + 1'b1;
          hold_cnt <= HOLD_LOAD;
          if (last) begin
            frame_done_out    <= 1'b1;
            emitted_count_out <= count + 1'b1;
            state             <= ST_DONE;
          end else begin
            index        <= index + 1'b1;
            mem_addr_out <= index + 1'b1;
            state        <= ST_FETCH;
          end
        end
        ST_DONE: begin
          busy_out <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          busy_out <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/particle_streamer.md
PARTICLE_STREAMER -- requirements
Module: particle_streamer

Interface
REQ-001 SHALL have parameter NUM_PARTICLES, default 64, meaning particles per frame pass; legal range 1..2^ADDR_W.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning position-memory address width.
REQ-003 SHALL have parameter MEM_LATENCY, default 2, meaning position-memory read latency in cycles.
REQ-004 SHALL have parameter READY_HOLDOFF, default 2, meaning cycles render_ready_in is ignored after each emit.
REQ-005 SHALL have port clk_in, input, 1, the only clock.
REQ-006 SHALL have port rst_in, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port frame_start_in, input, 1, a one-cycle pulse that starts a pass.
REQ-008 SHALL have port mem_addr_out, output, ADDR_W, the position-memory read address.
REQ-009 SHALL have port mem_data_in, input, 48, carrying {x[47:32], y[31:16], z[15:0]} as fp16.
REQ-010 SHALL have port render_ready_in, input, 1, the renderer ready level.
REQ-011 SHALL have ports f_x_out, f_y_out, f_z_out, output, 16 each, the particle coordinates.
REQ-012 SHALL have port data_valid_out, output, 1, a one-cycle coordinate strobe.
REQ-013 SHALL have port busy_out, output, 1, high while a pass is in progress.
REQ-014 SHALL have port frame_done_out, output, 1, a one-cycle end-of-pass pulse.
REQ-015 SHALL have port emitted_count_out, output, ADDR_W+1, the particles emitted in the last pass.

Function
REQ-016 SHALL sequence states IDLE -> FETCH -> WAIT_RDY -> EMIT -> (FETCH | DONE) -> IDLE.
REQ-017 IDLE: on frame_start_in SHALL clear the index and running count, drive mem_addr_out=0 and enter FETCH.
REQ-018 FETCH: SHALL hold mem_addr_out=index for MEM_LATENCY cycles, then register mem_data_in into the coordinate holding registers.
REQ-019 FETCH cull: when the z sign bit (mem_data_in[15]) is 1, or z is ±0, SHALL skip emission and advance the index (or go to DONE if last).
REQ-020 WAIT_RDY: SHALL count down the holdoff counter, then advance to EMIT on the first cycle render_ready_in=1 with the counter at 0.
REQ-021 EMIT: SHALL assert data_valid_out for exactly one cycle, with f_x/y/z_out valid that cycle, increment the running count and load holdoff=READY_HOLDOFF.
REQ-022 f_x/y/z_out SHALL hold their last emitted value between strobes.
REQ-023 EMIT with index=NUM_PARTICLES-1 SHALL go to DONE; otherwise SHALL increment the index and go to FETCH.
REQ-024 DONE: SHALL pulse frame_done_out for one cycle, latch emitted_count_out and return to IDLE.
REQ-025 busy_out SHALL be 1 in every state except IDLE.
REQ-026 frame_start_in outside IDLE SHALL be ignored, with no queuing.
REQ-027 With render_ready_in held high, per-particle throughput SHALL be MEM_LATENCY+READY_HOLDOFF+2 cycles.
REQ-028 The index SHALL never wrap past NUM_PARTICLES-1.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 Asserting rst_in at any time, including mid-pass, SHALL immediately force IDLE.
REQ-031 Reset SHALL zero mem_addr_out, f_x/y/z_out, data_valid_out, busy_out, frame_done_out, emitted_count_out and all counters.
REQ-032 A pass interrupted by reset SHALL NOT produce frame_done_out.

Structure
REQ-033 The state enum, the fp16 field-slice constants and the 48-bit position word width SHALL live in shared package render_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; the latency and holdoff counters are inline.

Verification
REQ-035 NUM_PARTICLES=4, all z=0x3C00, ready tied 1 -> 4 strobes 6 cycles apart in x/y/z memory order, frame_done_out pulse, emitted_count_out=4.
REQ-036 Particle 2 has z=0xBC00 -> 3 strobes, particle 2 absent, emitted_count_out=3.
REQ-037 render_ready_in held 0 for 20 cycles after the first strobe -> no second strobe until ready rises, and that strobe occurs 1 cycle after the rise.
REQ-038 Ready held high during holdoff -> no strobe within READY_HOLDOFF cycles of the previous strobe.
REQ-039 frame_start_in pulsed mid-pass -> no restart and exactly NUM_PARTICLES strobes total.
REQ-040 rst_in pulsed during WAIT_RDY -> all outputs 0 within the same cycle, no frame_done_out; a new frame_start_in yields a full pass from address 0.
